// File: rtl/main_scu_clk_en_requester.sv
// main_scu_clk_en_requester
// Initiator side of the SCU clock-enable set/clr/sta handshake. Each client
// gets its own small FSM that gates the client clock after a programmable
// number of idle cycles, wakes it again on activity, and tracks whether the
// SCU status follows every set/clr pulse.
// Optional feature macro: SCU_CLK_REQ_ACK_TIMEOUT_EN adds the ack timers and
// the sticky ack_err_o bits. Without it the wait states wait indefinitely.
module main_scu_clk_en_requester #(
    parameter int p_client_num     = 32,
    parameter int p_idle_cnt_width = 16,
    parameter int p_ack_timeout    = 8
) (
    input  logic                        kernel_clk_i,
    input  logic                        resetn_i,
    input  logic [p_idle_cnt_width-1:0] cfg_idle_thresh_i,
    input  logic [p_client_num-1:0]     cfg_auto_gate_en_i,
    input  logic [p_client_num-1:0]     client_busy_i,
    input  logic [p_client_num-1:0]     client_wake_i,
    input  logic [p_client_num-1:0]     clk_en_sta_i,
    output logic [p_client_num-1:0]     clk_en_set_o,
    output logic [p_client_num-1:0]     clk_en_clr_o,
    output logic [p_client_num-1:0]     client_clk_rdy_o,
    output logic [p_client_num-1:0]     ack_err_o,
    input  logic                        err_clr_i
);

    typedef enum logic [2:0] {
        ST_SYNC     = 3'd0,
        ST_ON       = 3'd1,
        ST_CLR_WAIT = 3'd2,
        ST_OFF      = 3'd3,
        ST_SET_WAIT = 3'd4
    } state_t;

    state_t                      state_q    [p_client_num];
    logic [p_idle_cnt_width-1:0] idle_cnt_q [p_client_num];
    logic [p_idle_cnt_width-1:0] idle_inc   [p_client_num];
    logic [p_client_num-1:0]     act;
    logic [p_client_num-1:0]     set_q;
    logic [p_client_num-1:0]     clr_q;
    logic [p_client_num-1:0]     rdy_q;

`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
    localparam int AckW = (p_ack_timeout > 2) ? $clog2(p_ack_timeout) : 1;
    localparam logic [AckW-1:0] AckLast = AckW'(p_ack_timeout - 1);

    logic [AckW-1:0]         ack_q [p_client_num];
    logic [p_client_num-1:0] err_q;
`endif

    // A client counts as active when it is busy, asks to wake, or when auto
    // gating is switched off for it (per client or globally via thresh 0).
    always_comb begin
        act = client_busy_i | client_wake_i | ~cfg_auto_gate_en_i
            | {p_client_num{cfg_idle_thresh_i == '0}};
    end

    // Saturating next value of each idle counter.
    always_comb begin
        for (int i = 0; i < p_client_num; i++) begin
            idle_inc[i] = (&idle_cnt_q[i]) ? idle_cnt_q[i] : idle_cnt_q[i] + 1'b1;
        end
    end

    // Per-client gating FSMs with registered pulse, ready and error outputs.
    always_ff @(posedge kernel_clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < p_client_num; i++) begin
                state_q[i]    <= ST_SYNC;
                idle_cnt_q[i] <= '0;
`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
                ack_q[i]      <= '0;
`endif
            end
            set_q <= '0;
            clr_q <= '0;
            rdy_q <= '0;
`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
            err_q <= '0;
`endif
        end else begin
            set_q <= '0;
            clr_q <= '0;
`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
            if (err_clr_i) begin
                err_q <= '0;
            end
`endif
            for (int i = 0; i < p_client_num; i++) begin
                case (state_q[i])
                    ST_SYNC: begin
                        idle_cnt_q[i] <= '0;
                        if (clk_en_sta_i[i]) begin
                            state_q[i] <= ST_ON;
                            rdy_q[i]   <= 1'b1;
                        end else begin
                            state_q[i] <= ST_OFF;
                            rdy_q[i]   <= 1'b0;
                        end
                    end
                    ST_ON: begin
                        if (act[i]) begin
                            idle_cnt_q[i] <= '0;
                        end else if (idle_inc[i] >= cfg_idle_thresh_i) begin
                            clr_q[i]      <= 1'b1;
                            rdy_q[i]      <= 1'b0;
                            state_q[i]    <= ST_CLR_WAIT;
                            idle_cnt_q[i] <= '0;
`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
                            ack_q[i]      <= '0;
`endif
                        end else begin
                            idle_cnt_q[i] <= idle_inc[i];
                        end
                    end
                    ST_CLR_WAIT: begin
                        if (!clk_en_sta_i[i]) begin
                            state_q[i] <= ST_OFF;
                        end
`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
                        else if (ack_q[i] == AckLast) begin
                            err_q[i]   <= 1'b1;
                            state_q[i] <= ST_SYNC;
                        end else begin
                            ack_q[i] <= ack_q[i] + 1'b1;
                        end
`endif
                    end
                    ST_OFF: begin
                        if (act[i]) begin
                            set_q[i]   <= 1'b1;
                            state_q[i] <= ST_SET_WAIT;
`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
                            ack_q[i]   <= '0;
`endif
                        end
                    end
                    ST_SET_WAIT: begin
                        if (clk_en_sta_i[i]) begin
                            state_q[i]    <= ST_ON;
                            rdy_q[i]      <= 1'b1;
                            idle_cnt_q[i] <= '0;
                        end
`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
                        else if (ack_q[i] == AckLast) begin
                            err_q[i]   <= 1'b1;
                            state_q[i] <= ST_SYNC;
                        end else begin
                            ack_q[i] <= ack_q[i] + 1'b1;
                        end
`endif
                    end
                    default: begin
                        state_q[i] <= ST_SYNC;
                        rdy_q[i]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign clk_en_set_o     = set_q;
    assign clk_en_clr_o     = clr_q;
    assign client_clk_rdy_o = rdy_q;

`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
    assign ack_err_o = err_q;
`else
    // Error reporting is compiled out; err_clr_i is folded into a constant
    // zero so the port stays referenced.
    assign ack_err_o = {p_client_num{err_clr_i & 1'b0}};
`endif

endmodule

// File: tb/tb_main_scu_clk_en_requester.sv
// tb_main_scu_clk_en_requester
// Self-checking bench: directed scenarios followed by randomized traffic,
// compared every cycle against a behavioural per-client model and a model of
// the SCU misc status register (optionally stuck to provoke ack timeouts).
module tb_main_scu_clk_en_requester;

    localparam int N  = 32;
    localparam int W  = 16;
    localparam int TO = 8;

    localparam int M_SYNC = 0;
    localparam int M_ON   = 1;
    localparam int M_CLRW = 2;
    localparam int M_OFF  = 3;
    localparam int M_SETW = 4;

    logic         kernel_clk_i = 1'b0;
    logic         resetn_i;
    logic [W-1:0] cfg_idle_thresh_i;
    logic [N-1:0] cfg_auto_gate_en_i;
    logic [N-1:0] client_busy_i;
    logic [N-1:0] client_wake_i;
    logic [N-1:0] clk_en_sta_i;
    logic [N-1:0] clk_en_set_o;
    logic [N-1:0] clk_en_clr_o;
    logic [N-1:0] client_clk_rdy_o;
    logic [N-1:0] ack_err_o;
    logic         err_clr_i;

    int checks   = 0;
    int failures = 0;

    int           m_mode  [N];
    int           m_idle  [N];
    int           m_timer [N];
    logic [N-1:0] exp_set, exp_clr, exp_rdy, exp_err;
    logic [N-1:0] last_clr;
    logic [N-1:0] scu_reg;
    logic [N-1:0] stuck;
    bit           timeout_en;

    // Stimulus currently applied; the model reads these, never the DUT.
    logic [W-1:0] s_thresh;
    logic [N-1:0] s_auto, s_busy, s_wake;
    logic         s_eclr;

    main_scu_clk_en_requester #(
        .p_client_num     (N),
        .p_idle_cnt_width (W),
        .p_ack_timeout    (TO)
    ) dut (
        .kernel_clk_i       (kernel_clk_i),
        .resetn_i           (resetn_i),
        .cfg_idle_thresh_i  (cfg_idle_thresh_i),
        .cfg_auto_gate_en_i (cfg_auto_gate_en_i),
        .client_busy_i      (client_busy_i),
        .client_wake_i      (client_wake_i),
        .clk_en_sta_i       (clk_en_sta_i),
        .clk_en_set_o       (clk_en_set_o),
        .clk_en_clr_o       (clk_en_clr_o),
        .client_clk_rdy_o   (client_clk_rdy_o),
        .ack_err_o          (ack_err_o),
        .err_clr_i          (err_clr_i)
    );

    // Free-running kernel clock.
    always #5 kernel_clk_i = ~kernel_clk_i;

    task automatic checkOutput(input string tag, input logic [N-1:0] actual,
                               input logic [N-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [N-1:0] sparse(input int odds);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = ($urandom_range(odds - 1) == 0);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i]  = M_SYNC;
            m_idle[i]  = 0;
            m_timer[i] = 0;
        end
        exp_set  = '0;
        exp_clr  = '0;
        exp_rdy  = '0;
        exp_err  = '0;
        last_clr = '0;
        scu_reg  = 32'h1;
    endtask

    // Advance the model by one kernel clock using the stimulus in s_*.
    task automatic model_step(input logic [N-1:0] sta);
        logic [N-1:0] nset, nclr, nrdy, nerr;
        bit a;
        int max_idle;
        max_idle = (1 << W) - 1;
        nset = '0;
        nclr = '0;
        nrdy = '0;
        nerr = s_eclr ? '0 : exp_err;
        for (int i = 0; i < N; i++) begin
            a = s_busy[i] || s_wake[i] || !s_auto[i] || (s_thresh == 0);
            if (m_mode[i] == M_SYNC) begin
                m_mode[i] = sta[i] ? M_ON : M_OFF;
                m_idle[i] = 0;
            end else if (m_mode[i] == M_ON) begin
                if (a) begin
                    m_idle[i] = 0;
                end else begin
                    m_idle[i] = (m_idle[i] < max_idle) ? m_idle[i] + 1 : max_idle;
                    if (m_idle[i] >= int'(s_thresh)) begin
                        nclr[i]    = 1'b1;
                        m_mode[i]  = M_CLRW;
                        m_idle[i]  = 0;
                        m_timer[i] = 0;
                    end
                end
            end else if (m_mode[i] == M_OFF) begin
                if (a) begin
                    nset[i]    = 1'b1;
                    m_mode[i]  = M_SETW;
                    m_timer[i] = 0;
                end
            end else begin
                if ((m_mode[i] == M_CLRW && !sta[i]) || (m_mode[i] == M_SETW && sta[i])) begin
                    m_mode[i] = (m_mode[i] == M_CLRW) ? M_OFF : M_ON;
                    m_idle[i] = 0;
                end else if (timeout_en) begin
                    m_timer[i]++;
                    if (m_timer[i] == TO) begin
                        nerr[i]   = 1'b1;
                        m_mode[i] = M_SYNC;
                    end
                end
            end
            nrdy[i] = (m_mode[i] == M_ON);
        end
        exp_set = nset;
        exp_clr = nclr;
        exp_rdy = nrdy;
        exp_err = nerr;
    endtask

    // Drive one cycle of stimulus, update the SCU model and the client model.
    task automatic applyStimulus(input logic [N-1:0] busy, input logic [N-1:0] wake,
                                 input logic [N-1:0] auto_en, input logic [W-1:0] thresh,
                                 input logic eclr);
        logic [N-1:0] sta_now;
        s_busy   = busy;
        s_wake   = wake;
        s_auto   = auto_en;
        s_thresh = thresh;
        s_eclr   = eclr;
        sta_now  = scu_reg;
        scu_reg  = (((scu_reg | exp_set) & ~exp_clr) & ~stuck) | (scu_reg & stuck);
        client_busy_i      = busy;
        client_wake_i      = wake;
        cfg_auto_gate_en_i = auto_en;
        cfg_idle_thresh_i  = thresh;
        err_clr_i          = eclr;
        clk_en_sta_i       = sta_now;
        model_step(sta_now);
    endtask

    // Compare all outputs mid-cycle, then apply the next stimulus.
    task automatic cycle(input logic [N-1:0] busy, input logic [N-1:0] wake,
                         input logic [N-1:0] auto_en, input logic [W-1:0] thresh,
                         input logic eclr);
        @(negedge kernel_clk_i);
        checkOutput("set", clk_en_set_o, exp_set);
        checkOutput("clr", clk_en_clr_o, exp_clr);
        checkOutput("rdy", client_clk_rdy_o, exp_rdy);
        checkOutput("err", ack_err_o, exp_err);
        checkOutput("set_and_clr", clk_en_set_o & clk_en_clr_o, '0);
        last_clr = exp_clr;
        applyStimulus(busy, wake, auto_en, thresh, eclr);
    endtask

    // Asynchronous reset at an arbitrary point, released on a falling edge.
    task automatic do_reset(input logic [N-1:0] auto_en, input logic [W-1:0] thresh);
        #2;
        resetn_i = 1'b0;
        #1;
        checkOutput("rst_set", clk_en_set_o, '0);
        checkOutput("rst_clr", clk_en_clr_o, '0);
        checkOutput("rst_rdy", client_clk_rdy_o, '0);
        checkOutput("rst_err", ack_err_o, '0);
        model_reset();
        stuck        = '0;
        clk_en_sta_i = scu_reg;
        @(negedge kernel_clk_i);
        @(negedge kernel_clk_i);
        checkOutput("rst_hold_rdy", client_clk_rdy_o, '0);
        resetn_i = 1'b1;
        applyStimulus('0, '0, auto_en, thresh, 1'b0);
    endtask

    initial begin
        int clr_seen;
        int clr_count;
        logic [N-1:0] b3;
`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
        timeout_en = 1'b1;
`else
        timeout_en = 1'b0;
`endif
        stuck    = '0;
        resetn_i = 1'b1;
        cfg_idle_thresh_i  = 16;
        cfg_auto_gate_en_i = '1;
        client_busy_i      = '0;
        client_wake_i      = '0;
        clk_en_sta_i       = 32'h1;
        err_clr_i          = 1'b0;
        model_reset();

        // Reset, release with sta = 1 on client 0 only, then let client 0 idle.
        do_reset('1, 16);
        b3 = 32'h8;
        for (int j = 1; j <= 30; j++) begin
            cycle((j >= 17) ? 32'h1 : 32'h0, (j == 25) ? b3 : '0, '1, 16, 1'b0);
            if (j == 1)  checkOutput("t1_rdy_after_release", client_clk_rdy_o, 32'h1);
            if (j == 16) checkOutput("t2_no_clr_early", clk_en_clr_o, '0);
            if (j == 17) checkOutput("t2_clr_at_idle16", clk_en_clr_o, 32'h1);
            if (j == 18) checkOutput("t2_rdy_dropped", client_clk_rdy_o & 32'h1, '0);
            if (j == 20) checkOutput("t4_set_after_clr", clk_en_set_o, 32'h1);
            if (j == 26) checkOutput("t3_set_same", clk_en_set_o & b3, b3);
            if (j == 27) checkOutput("t3_rdy_not_yet", client_clk_rdy_o & b3, '0);
            if (j == 28) checkOutput("t3_rdy_up", client_clk_rdy_o & b3, b3);
        end

`ifdef SCU_CLK_REQ_ACK_TIMEOUT_EN
        // Client 3 gates while the SCU ignores it: ack timeout, resync, clear.
        stuck    = b3;
        clr_seen = -1;
        for (int j = 0; j < 60; j++) begin
            cycle(32'h1, '0, '1, 16, (clr_seen >= 0 && j == clr_seen + 10));
            if (clr_seen < 0 && last_clr[3]) clr_seen = j;
            if (clr_seen >= 0 && j == clr_seen + 7) checkOutput("t5_err_not_yet", ack_err_o & b3, '0);
            if (clr_seen >= 0 && j == clr_seen + 8) checkOutput("t5_err_set", ack_err_o & b3, b3);
            if (clr_seen >= 0 && j == clr_seen + 9) checkOutput("t5_resync_on", client_clk_rdy_o & b3, b3);
            if (clr_seen >= 0 && j == clr_seen + 11) checkOutput("t5_err_cleared", ack_err_o & b3, '0);
        end
        if (clr_seen < 0) checkOutput("t5_clr_timeout", '0, b3);
        stuck = '0;
`endif

        // Auto gating disabled by thresh 0, then per client: no clr pulses.
        clr_count = 0;
        for (int j = 0; j < 1000; j++) begin
            cycle('0, '0, (j < 500) ? '1 : '0, (j < 500) ? 16'd0 : 16'd5, 1'b0);
            if (j > 1 && j != 501) clr_count += $countones(clk_en_clr_o);
        end
        checkOutput("t6_no_clr_pulses", N'(clr_count), '0);
        checkOutput("t6_all_rdy", client_clk_rdy_o, '1);

        // Randomized traffic with occasional threshold, enable and SCU changes.
        for (int p = 0; p < 16; p++) begin
            logic [N-1:0] auto_en;
            logic [W-1:0] thresh;
            auto_en = ~sparse(4);
            thresh  = ($urandom_range(7) == 0) ? 16'd0 : W'($urandom_range(24, 1));
            stuck   = timeout_en ? sparse(6) : '0;
            for (int j = 0; j < 200; j++) begin
                if ($urandom_range(49) == 0) thresh = W'($urandom_range(24, 1));
                cycle(sparse(10), sparse(40), auto_en, thresh, ($urandom_range(30) == 0));
            end
            if (p == 7) do_reset(auto_en, thresh);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
